// File: rtl/note_sequencer.sv
// Steps through an 8-note C4..C5 scale, producing a line-rate square wave per note
// with optional silent gaps. Timing is derived from the sync generator's line/frame strobes.
module note_sequencer #(
    parameter int FRAMES_PER_NOTE = 16,
    parameter int GAP_FRAMES      = 4,
    parameter int DIV_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_enable,
    input  logic       i_line_tick,
    input  logic       i_frame_tick,
    output logic       o_sound,
    output logic [2:0] o_note_idx,
    output logic       o_playing,
    output logic       o_note_start
);

    localparam int FMAX = (FRAMES_PER_NOTE > GAP_FRAMES) ? FRAMES_PER_NOTE : GAP_FRAMES;
    localparam int FC_W = $clog2(FMAX + 1);
    localparam logic [FC_W-1:0] PLAY_LAST = FC_W'(FRAMES_PER_NOTE - 1);
    localparam logic [FC_W-1:0] GAP_LAST  = FC_W'((GAP_FRAMES > 0) ? (GAP_FRAMES - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Half-period (minus one) in scan lines for each scale step.
    function automatic logic [DIV_W-1:0] note_div(input logic [2:0] idx);
        case (idx)
            3'd0:    note_div = DIV_W'(8'd60);
            3'd1:    note_div = DIV_W'(8'd54);
            3'd2:    note_div = DIV_W'(8'd48);
            3'd3:    note_div = DIV_W'(8'd45);
            3'd4:    note_div = DIV_W'(8'd40);
            3'd5:    note_div = DIV_W'(8'd36);
            3'd6:    note_div = DIV_W'(8'd32);
            3'd7:    note_div = DIV_W'(8'd30);
            default: note_div = DIV_W'(8'd60);
        endcase
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic [FC_W-1:0]   r_frame_cnt,  w_frame_cnt_nx;
    logic [DIV_W-1:0]  r_line_cnt,   w_line_cnt_nx;
    logic              r_wave,       w_wave_nx;
    logic [2:0]        r_note_idx,   w_note_idx_nx;
    logic              r_sound,      w_sound_nx;
    logic              r_playing,    w_playing_nx;
    logic              r_note_start, w_note_start_nx;
    logic              w_play_end;
    logic              w_gap_end;
    logic              w_advance;
    logic              w_entry;
    logic [DIV_W-1:0]  w_div;

    assign w_div = note_div(r_note_idx);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and note-boundary decode.
    always_comb begin
        w_play_end = (r_state == S_PLAY) && i_frame_tick && (r_frame_cnt == PLAY_LAST);
        w_gap_end  = (GAP_FRAMES > 0) && (r_state == S_GAP) && i_frame_tick &&
                     (r_frame_cnt == GAP_LAST);
        w_advance  = i_enable && ((w_play_end && (GAP_FRAMES == 0)) || w_gap_end);
        w_entry    = i_enable && ((r_state == S_IDLE) || w_advance);
        w_next_state = r_state;
        if (!i_enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_next_state = S_PLAY;
                S_PLAY: begin
                    if (w_play_end && (GAP_FRAMES > 0)) begin
                        w_next_state = S_GAP;
                    end else begin
                        w_next_state = S_PLAY;
                    end
                end
                S_GAP: begin
                    if (w_gap_end) begin
                        w_next_state = S_PLAY;
                    end else begin
                        w_next_state = S_GAP;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // Output / datapath next values; a note advance overrides a coincident wave update.
    always_comb begin
        w_frame_cnt_nx = r_frame_cnt;
        w_line_cnt_nx  = r_line_cnt;
        w_wave_nx      = r_wave;
        w_note_idx_nx  = r_note_idx;
        if ((w_next_state == S_IDLE) || (r_state == S_IDLE)) begin
            w_frame_cnt_nx = '0;
            w_line_cnt_nx  = '0;
            w_wave_nx      = 1'b0;
            w_note_idx_nx  = 3'd0;
        end else begin
            if (i_frame_tick) begin
                if (w_play_end || w_gap_end) begin
                    w_frame_cnt_nx = '0;
                end else begin
                    w_frame_cnt_nx = r_frame_cnt + FC_W'(1'b1);
                end
            end else begin
                w_frame_cnt_nx = r_frame_cnt;
            end
            if (w_advance) begin
                w_note_idx_nx = r_note_idx + 3'd1;
            end else begin
                w_note_idx_nx = r_note_idx;
            end
            if (w_advance || (w_next_state != S_PLAY)) begin
                w_line_cnt_nx = '0;
                w_wave_nx     = 1'b0;
            end else if (i_line_tick) begin
                if (r_line_cnt >= w_div) begin
                    w_line_cnt_nx = '0;
                    w_wave_nx     = ~r_wave;
                end else begin
                    w_line_cnt_nx = r_line_cnt + DIV_W'(1'b1);
                    w_wave_nx     = r_wave;
                end
            end else begin
                w_line_cnt_nx = r_line_cnt;
                w_wave_nx     = r_wave;
            end
        end
        w_playing_nx    = (w_next_state == S_PLAY);
        w_sound_nx      = w_wave_nx & w_playing_nx;
        w_note_start_nx = w_entry;
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_line_cnt   <= '0;
            r_wave       <= 1'b0;
            r_note_idx   <= 3'd0;
            r_sound      <= 1'b0;
            r_playing    <= 1'b0;
            r_note_start <= 1'b0;
        end else begin
            r_frame_cnt  <= w_frame_cnt_nx;
            r_line_cnt   <= w_line_cnt_nx;
            r_wave       <= w_wave_nx;
            r_note_idx   <= w_note_idx_nx;
            r_sound      <= w_sound_nx;
            r_playing    <= w_playing_nx;
            r_note_start <= w_note_start_nx;
        end
    end

    assign o_sound      = r_sound;
    assign o_note_idx   = r_note_idx;
    assign o_playing    = r_playing;
    assign o_note_start = r_note_start;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a default instance (16 play / 4 gap frames) and a
// no-gap instance (2 play frames) share the same stimulus.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       line_tick = 1'b0;
    logic       frame_tick = 1'b0;
    logic       sound, playing, note_start;
    logic [2:0] note_idx;
    logic       ng_sound, ng_playing, ng_note_start;
    logic [2:0] ng_note_idx;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    note_sequencer #(.FRAMES_PER_NOTE(16), .GAP_FRAMES(4), .DIV_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_line_tick(line_tick),
        .i_frame_tick(frame_tick), .o_sound(sound), .o_note_idx(note_idx),
        .o_playing(playing), .o_note_start(note_start)
    );

    note_sequencer #(.FRAMES_PER_NOTE(2), .GAP_FRAMES(0), .DIV_W(8)) dut_ng (
        .clk(clk), .rst_n(rst_n), .i_enable(enable), .i_line_tick(line_tick),
        .i_frame_tick(frame_tick), .o_sound(ng_sound), .o_note_idx(ng_note_idx),
        .o_playing(ng_playing), .o_note_start(ng_note_start)
    );

    task automatic step(input logic l, input logic f);
        @(negedge clk);
        line_tick  = l;
        frame_tick = f;
        @(posedge clk);
        #1;
        line_tick  = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic frame_pulse();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({sound, playing, note_start, note_idx} !== 6'b000_000) begin
            n_errors++;
            $display("FAIL reset_outputs got s=%b p=%b ns=%b n=%0d want all 0",
                     sound, playing, note_start, note_idx);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({playing, note_start, note_idx, sound} !== 6'b11_000_0) begin
            n_errors++;
            $display("FAIL start_entry got p=%b ns=%b n=%0d s=%b want p=1 ns=1 n=0 s=0",
                     playing, note_start, note_idx, sound);
        end
        step(1'b0, 1'b0);
        n_checks++;
        if ({playing, note_start} !== 2'b10) begin
            n_errors++;
            $display("FAIL start_pulse_width got p=%b ns=%b want p=1 ns=0", playing, note_start);
        end
    endtask

    task automatic test_wave();
        logic exp_s;
        exp_s = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            step(1'b1, 1'b0);
            if ((k % 61) == 0) exp_s = ~exp_s;
            n_checks++;
            if (sound !== exp_s) begin
                n_errors++;
                $display("FAIL wave_c4 tick=%0d got %b want %b", k, sound, exp_s);
            end
        end
    endtask

    task automatic test_play_gap();
        for (int f = 1; f <= 16; f++) begin
            frame_pulse();
            if (f < 16) begin
                n_checks++;
                if ({playing, note_idx} !== 4'b1_000) begin
                    n_errors++;
                    $display("FAIL play_hold frame=%0d got p=%b n=%0d want p=1 n=0",
                             f, playing, note_idx);
                end
            end else begin
                n_checks++;
                if ({playing, sound} !== 2'b00) begin
                    n_errors++;
                    $display("FAIL gap_entry got p=%b s=%b want 0 0", playing, sound);
                end
            end
        end
        for (int g = 1; g <= 4; g++) begin
            step(1'b0, 1'b1);
            if (g < 4) begin
                n_checks++;
                if ({playing, sound} !== 2'b00) begin
                    n_errors++;
                    $display("FAIL gap_hold frame=%0d got p=%b s=%b want 0 0", g, playing, sound);
                end
            end else begin
                n_checks++;
                if ({playing, note_start, note_idx} !== 5'b11_001) begin
                    n_errors++;
                    $display("FAIL note1_entry got p=%b ns=%b n=%0d want 1 1 1",
                             playing, note_start, note_idx);
                end
            end
            step(1'b0, 1'b0);
        end
        n_checks++;
        if (note_start !== 1'b0) begin
            n_errors++;
            $display("FAIL note1_pulse_width got %b want 0", note_start);
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_n;
        for (int n = 1; n <= 7; n++) begin
            for (int f = 1; f < 20; f++) frame_pulse();
            step(1'b0, 1'b1);
            exp_n = 3'((n + 1) % 8);
            n_checks++;
            if ({note_start, note_idx} !== {1'b1, exp_n}) begin
                n_errors++;
                $display("FAIL advance_from_%0d got ns=%b n=%0d want ns=1 n=%0d",
                         n, note_start, note_idx, exp_n);
            end
            step(1'b0, 1'b0);
        end
    endtask

    task automatic test_disable();
        for (int f = 1; f <= 65; f++) frame_pulse();
        n_checks++;
        if ({playing, note_idx} !== 4'b1_011) begin
            n_errors++;
            $display("FAIL reach_note3 got p=%b n=%0d want p=1 n=3", playing, note_idx);
        end
        for (int k = 1; k <= 46; k++) begin
            step(1'b1, 1'b0);
            if (k == 45) begin
                n_checks++;
                if (sound !== 1'b0) begin
                    n_errors++;
                    $display("FAIL wave_f4_before tick=45 got %b want 0", sound);
                end
            end else if (k == 46) begin
                n_checks++;
                if (sound !== 1'b1) begin
                    n_errors++;
                    $display("FAIL wave_f4_rise tick=46 got %b want 1", sound);
                end
            end else begin
            end
        end
        enable = 1'b0;
        step(1'b0, 1'b0);
        n_checks++;
        if ({sound, playing, note_start, note_idx} !== 6'b000_000) begin
            n_errors++;
            $display("FAIL disable got s=%b p=%b ns=%b n=%0d want all 0",
                     sound, playing, note_start, note_idx);
        end
        step(1'b0, 1'b1);
        enable = 1'b1;
        step(1'b0, 1'b0);
        n_checks++;
        if ({playing, note_start, note_idx} !== 5'b11_000) begin
            n_errors++;
            $display("FAIL reenable got p=%b ns=%b n=%0d want 1 1 0",
                     playing, note_start, note_idx);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({playing, ng_playing, note_idx} !== 5'b00_000) begin
            n_errors++;
            $display("FAIL async_reset got p=%b ngp=%b n=%0d want 0 0 0",
                     playing, ng_playing, note_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({ng_playing, ng_note_start, ng_note_idx} !== 5'b11_000) begin
            n_errors++;
            $display("FAIL ng_start got p=%b ns=%b n=%0d want 1 1 0",
                     ng_playing, ng_note_start, ng_note_idx);
        end
        step(1'b0, 1'b1);
        for (int k = 1; k <= 61; k++) step(1'b1, 1'b0);
        n_checks++;
        if (ng_sound !== 1'b1) begin
            n_errors++;
            $display("FAIL ng_wave_high got %b want 1", ng_sound);
        end
        step(1'b1, 1'b1);
        n_checks++;
        if ({ng_playing, ng_note_start, ng_note_idx, ng_sound} !== 6'b11_001_0) begin
            n_errors++;
            $display("FAIL ng_simul_advance got p=%b ns=%b n=%0d s=%b want 1 1 1 0",
                     ng_playing, ng_note_start, ng_note_idx, ng_sound);
        end
        for (int k = 1; k <= 55; k++) begin
            step(1'b1, 1'b0);
            if (k == 54) begin
                n_checks++;
                if (ng_sound !== 1'b0) begin
                    n_errors++;
                    $display("FAIL ng_d4_before tick=54 got %b want 0", ng_sound);
                end
            end else if (k == 55) begin
                n_checks++;
                if (ng_sound !== 1'b1) begin
                    n_errors++;
                    $display("FAIL ng_d4_rise tick=55 got %b want 1", ng_sound);
                end
            end else begin
            end
        end
    endtask

    initial begin
        test_reset();
        test_wave();
        test_play_gap();
        test_wrap();
        test_disable();
        test_simultaneous();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
